sha256_digest_reader: RTL and testbench

//  Read-side counterpart of the H0..H7 digest accumulators. Captures the eight 32-bit

---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_digest_reader.sv | 102 ++++++++++
 tb/tb_sha256_digest_reader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: initial hash values, digest geometry,
// the digest reader state encoding and a byte-reversal helper.
package sha256_pkg;

    localparam int DIGEST_W = 256;
    localparam int WORD_W   = 32;
    localparam int N_WORDS  = DIGEST_W / WORD_W;

    // Initial hash value H0..H7 (FIPS 180-4).
    localparam logic [31:0] SHA256_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Digest reader: idle (can take a digest) or streaming words out.
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Reverse byte order of a 32-bit word (big-endian <-> little-endian).
    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_digest_reader.sv
// Captures a completed 256-bit digest (plus side tag) and streams it out
// one 32-bit word per handshake, H0 first. One digest is buffered; a digest
// offered while busy is dropped and recorded in the sticky overrun flag.
module sha256_digest_reader
    import sha256_pkg::*;
#(
    parameter int BYTE_SWAP = 0,
    parameter int TAG_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dig_valid,
    input  logic [DIGEST_W-1:0] dig_in,
    input  logic [TAG_W-1:0]    dig_tag,
    output logic                dig_ready,
    output logic [WORD_W-1:0]   out_word,
    output logic [2:0]          out_idx,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    rd_state_e                        state_q, state_d;
    // Element 7 holds H0 (bits 255:224), element 0 holds H7.
    logic [N_WORDS-1:0][WORD_W-1:0]   buf_q, buf_d;
    logic [2:0]                       idx_q, idx_d;
    logic [TAG_W-1:0]                 tag_q, tag_d;
    logic                             overrun_q, overrun_d;

    logic                             accept;
    logic                             handshake;
    logic                             last_word;
    logic [WORD_W-1:0]                word_raw;

    assign out_valid = (state_q == RD_STREAM);
    assign last_word = (idx_q == 3'd7);
    assign out_last  = out_valid && last_word;
    assign handshake = out_valid && out_ready;
    // Ready also during the final handshake so consecutive digests stream
    // without a bubble cycle.
    assign dig_ready = (state_q == RD_IDLE) || (out_last && out_ready);
    assign accept    = dig_valid && dig_ready;
    assign word_raw  = buf_q[3'd7 - idx_q];

    assign out_idx   = idx_q;
    assign out_tag   = tag_q;
    assign overrun   = overrun_q;

    // Output byte order is fixed at elaboration time.
    generate
        if (BYTE_SWAP != 0) begin : g_swap
            assign out_word = bswap32(word_raw);
        end else begin : g_pass
            assign out_word = word_raw;
        end
    endgenerate

    // Next-state: capture on accept, advance word index on handshake,
    // sticky overrun where a new drop beats a simultaneous clear.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        overrun_d = (overrun_q && !overrun_clr) || (dig_valid && !dig_ready);

        if (accept) begin
            buf_d   = dig_in;
            tag_d   = dig_tag;
            idx_d   = 3'd0;
            state_d = RD_STREAM;
        end else if (handshake) begin
            if (last_word) begin
                idx_d   = 3'd0;
                state_d = RD_IDLE;
            end else begin
                idx_d   = idx_q + 3'd1;
            end
        end
    end

    // State register; reset abandons any digest in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            buf_q     <= '0;
            idx_q     <= 3'd0;
            tag_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed bench for sha256_digest_reader: two instances (plain and
// byte-swapped) share stimulus; a scoreboard queue holds expected words.
module tb_sha256_digest_reader;
    import sha256_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dig_valid;
    logic [255:0] dig_in;
    logic [31:0]  dig_tag;
    logic         out_ready;
    logic         overrun_clr;

    logic         dig_ready,  dig_ready_sw;
    logic [31:0]  out_word,   out_word_sw;
    logic [2:0]   out_idx,    out_idx_sw;
    logic [31:0]  out_tag,    out_tag_sw;
    logic         out_valid,  out_valid_sw;
    logic         out_last,   out_last_sw;
    logic         overrun,    overrun_sw;

    always #5 clk = ~clk;

    sha256_digest_reader #(.BYTE_SWAP(0), .TAG_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .dig_valid(dig_valid), .dig_in(dig_in),
        .dig_tag(dig_tag), .dig_ready(dig_ready), .out_word(out_word),
        .out_idx(out_idx), .out_tag(out_tag), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    sha256_digest_reader #(.BYTE_SWAP(1), .TAG_W(32)) u_dut_sw (
        .clk(clk), .rst_n(rst_n), .dig_valid(dig_valid), .dig_in(dig_in),
        .dig_tag(dig_tag), .dig_ready(dig_ready_sw), .out_word(out_word_sw),
        .out_idx(out_idx_sw), .out_tag(out_tag_sw), .out_valid(out_valid_sw),
        .out_last(out_last_sw), .out_ready(out_ready), .overrun(overrun_sw),
        .overrun_clr(overrun_clr)
    );

    int total = 0;
    int bad   = 0;
    int hs_count = 0;

    logic [31:0] exp_w[$];
    logic [31:0] exp_sw[$];
    int          exp_i[$];
    logic [31:0] exp_t[$];

    logic        stall_prev = 1'b0;
    logic [31:0] held_word;
    logic [2:0]  held_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic push_digest(input logic [255:0] d, input logic [31:0] t);
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            w = d[255 - 32*k -: 32];
            exp_w.push_back(w);
            exp_sw.push_back(swap_bytes(w));
            exp_i.push_back(k);
            exp_t.push_back(t);
        end
    endtask

    // One clock: check outputs at the falling edge, then let the rising edge act.
    task automatic step();
        logic [31:0] ew, esw, et;
        int          ei;
        @(negedge clk);
        chk("valid_match_sw", {63'd0, out_valid_sw}, {63'd0, out_valid});
        if (out_valid && stall_prev) begin
            chk("hold_word", {32'd0, out_word}, {32'd0, held_word});
            chk("hold_idx", {61'd0, out_idx}, {61'd0, held_idx});
        end
        stall_prev = out_valid && !out_ready;
        held_word  = out_word;
        held_idx   = out_idx;
        if (out_valid && out_ready) begin
            hs_count++;
            if (exp_w.size() == 0) begin
                chk("unexpected_word", {61'd0, out_idx}, 64'hffff_ffff_ffff_ffff);
            end else begin
                ew  = exp_w.pop_front();
                esw = exp_sw.pop_front();
                ei  = exp_i.pop_front();
                et  = exp_t.pop_front();
                $display("word idx=%0d data=%h swapped=%h tag=%h last=%0b",
                         out_idx, out_word, out_word_sw, out_tag, out_last);
                chk("word", {32'd0, out_word}, {32'd0, ew});
                chk("word_swapped", {32'd0, out_word_sw}, {32'd0, esw});
                chk("idx", {61'd0, out_idx}, 64'(ei));
                chk("tag", {32'd0, out_tag}, {32'd0, et});
                chk("last", {63'd0, out_last}, {63'd0, (ei == 7)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer a digest while idle; expect acceptance and first word next cycle.
    task automatic send(input logic [255:0] d, input logic [31:0] t);
        dig_valid = 1'b1;
        dig_in    = d;
        dig_tag   = t;
        chk("dig_ready_idle", {63'd0, dig_ready}, 64'd1);
        push_digest(d, t);
        step();
        dig_valid = 1'b0;
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
        chk("latency_idx0", {61'd0, out_idx}, 64'd0);
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_w.size() > 0; c++) step();
        chk("drain_empty", 64'(exp_w.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_word", {32'd0, out_word}, 64'd0);
        chk("rst_idx", {61'd0, out_idx}, 64'd0);
        chk("rst_tag", {32'd0, out_tag}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        chk("rst_ready", {63'd0, dig_ready}, 64'd1);
        exp_w.delete(); exp_sw.delete(); exp_i.delete(); exp_t.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [255:0] dg_abc, dg_iv, dg_c, dg_d, dg_e, dg_junk;
    int           hs_before;
    logic         pat [0:3];

    initial begin
        dg_abc  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
        dg_iv   = {SHA256_IV[0], SHA256_IV[1], SHA256_IV[2], SHA256_IV[3],
                   SHA256_IV[4], SHA256_IV[5], SHA256_IV[6], SHA256_IV[7]};
        dg_c    = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
        dg_d    = 256'hdeadbeef_cafef00d_0badf00d_feedface_13579bdf_2468ace0_a5a5a5a5_5a5a5a5a;
        dg_e    = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        dg_junk = 256'hffffffff_eeeeeeee_dddddddd_cccccccc_bbbbbbbb_aaaaaaaa_99999999_00000000;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        dig_valid = 1'b0; dig_in = '0; dig_tag = '0;
        out_ready = 1'b1; overrun_clr = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // SHA-256("abc"), both byte orders checked through the scoreboard.
        send(dg_abc, 32'h1234);
        out_ready = 1'b1;
        drain(40);
        chk("abc_idle", {63'd0, out_valid}, 64'd0);

        // Backpressure: exactly 8 handshakes, words held while stalled.
        hs_before = hs_count;
        send(dg_iv, 32'hcafe0001);
        for (int c = 0; c < 100 && exp_w.size() > 0; c++) begin
            out_ready = pat[c % 4];
            step();
        end
        chk("bp_empty", 64'(exp_w.size()), 64'd0);
        chk("bp_handshakes", 64'(hs_count - hs_before), 64'd8);
        out_ready = 1'b1;
        step();
        chk("bp_idle", {63'd0, out_valid}, 64'd0);

        // Back-to-back: next digest offered during the word-7 handshake.
        send(dg_c, 32'h0000_0c0c);
        repeat (7) step();
        chk("b2b_idx7", {61'd0, out_idx}, 64'd7);
        chk("b2b_last", {63'd0, out_last}, 64'd1);
        dig_valid = 1'b1; dig_in = dg_d; dig_tag = 32'h0000_0d0d;
        chk("b2b_ready", {63'd0, dig_ready}, 64'd1);
        push_digest(dg_d, 32'h0000_0d0d);
        step();
        dig_valid = 1'b0;
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_idx0", {61'd0, out_idx}, 64'd0);
        chk("b2b_tag", {32'd0, out_tag}, 64'h0000_0d0d);
        drain(40);
        chk("b2b_overrun", {63'd0, overrun}, 64'd0);

        // Overrun: drop at idx 2, stream unaffected, then clear.
        send(dg_e, 32'h0000_0e0e);
        repeat (2) step();
        chk("ovr_idx2", {61'd0, out_idx}, 64'd2);
        dig_valid = 1'b1; dig_in = dg_junk; dig_tag = 32'hbad0bad0;
        chk("ovr_not_ready", {63'd0, dig_ready}, 64'd0);
        step();
        dig_valid = 1'b0;
        chk("ovr_set", {63'd0, overrun}, 64'd1);
        chk("ovr_idx3", {61'd0, out_idx}, 64'd3);
        drain(40);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", {63'd0, overrun}, 64'd0);

        // Clear and drop in the same cycle: set wins.
        send(dg_abc, 32'h0000_5555);
        dig_valid = 1'b1; dig_in = dg_junk;
        step();
        chk("ovr_set2", {63'd0, overrun}, 64'd1);
        overrun_clr = 1'b1;
        step();
        dig_valid = 1'b0; overrun_clr = 1'b0;
        chk("ovr_set_wins", {63'd0, overrun}, 64'd1);
        drain(40);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr2", {63'd0, overrun}, 64'd0);

        // Reset mid-stream at idx 3 with overrun set; nothing may follow.
        send(dg_iv, 32'h0000_7777);
        dig_valid = 1'b1; dig_in = dg_junk;
        step();
        dig_valid = 1'b0;
        repeat (2) step();
        chk("mid_idx3", {61'd0, out_idx}, 64'd3);
        chk("mid_overrun", {63'd0, overrun}, 64'd1);
        do_reset();
        out_ready = 1'b1;
        repeat (6) step();
        chk("post_rst_idle", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
